// File: rtl/game_round_if.sv
// Bus between the word-game round sequencer and its surroundings (player input, timer, display).
// master drives the player/timer inputs; slave is the sequencer.
interface game_round_if #(
  parameter int unsigned SCORE_W = 8,
  parameter int unsigned ROUND_W = 4
);
  logic               Start;
  logic               ModeSw;
  logic               WordDone;
  logic               WordCorrect;
  logic               Timeout;
  logic               TimerEnable;
  logic               ChildMode;
  logic               EnableScore;
  logic               NewWord;
  logic [SCORE_W-1:0] Score;
  logic [ROUND_W-1:0] Round;
  logic [1:0]         Misses;
  logic               GameOver;

  modport master (
    output Start, ModeSw, WordDone, WordCorrect, Timeout,
    input  TimerEnable, ChildMode, EnableScore, NewWord, Score, Round, Misses, GameOver
  );

  modport slave (
    input  Start, ModeSw, WordDone, WordCorrect, Timeout,
    output TimerEnable, ChildMode, EnableScore, NewWord, Score, Round, Misses, GameOver
  );
endinterface

// File: rtl/game_round_ctrl.sv
// Round sequencer for the word game: loads the countdown timer, judges each word, keeps score.
// Optional macro STREAK_BONUS_EN: third and later consecutive correct words score 2 instead of 1.
module game_round_ctrl #(
  parameter int unsigned NUM_ROUNDS  = 8,
  parameter int unsigned ROUND_W     = 4,
  parameter int unsigned SCORE_W     = 8,
  parameter int unsigned MAX_MISSES  = 3,
  parameter int unsigned HOLD_CYCLES = 100000000
) (
  input  logic Clk,
  input  logic Rst,
  game_round_if.slave bus
);

  localparam int unsigned HOLD_W = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;
  localparam logic [HOLD_W-1:0]  HOLD_LAST  = HOLD_W'(HOLD_CYCLES - 1);
  localparam logic [ROUND_W-1:0] ROUND_LAST = ROUND_W'(NUM_ROUNDS);
  localparam logic [1:0]         MISS_LAST  = 2'(MAX_MISSES);

  typedef enum logic [2:0] {
    S_IDLE, S_LOAD, S_ARM, S_PLAY, S_RESULT, S_OVER
  } state_t;

  state_t            state;
  logic [HOLD_W-1:0] hold_cnt;
  logic [1:0]        score_add_c;
  logic [SCORE_W:0]  score_sum_c;
  logic [SCORE_W-1:0] score_next_c;
  logic              start_game_c;
  logic              correct_c;
  logic              miss_c;

  // WordDone takes priority over a same-cycle Timeout
  assign correct_c    = bus.WordDone & bus.WordCorrect;
  assign miss_c       = (bus.WordDone & ~bus.WordCorrect) | (~bus.WordDone & bus.Timeout);
  assign start_game_c = bus.Start & ((state == S_IDLE) | (state == S_OVER));

`ifdef STREAK_BONUS_EN
  logic [1:0] streak;

  // Consecutive-correct counter, saturating at 3
  always_ff @(posedge Clk) begin
    if (Rst || start_game_c) begin
      streak <= 2'd0;
    end else if (state == S_PLAY) begin
      if (correct_c) begin
        streak <= (streak == 2'd3) ? 2'd3 : streak + 2'd1;
      end else if (miss_c) begin
        streak <= 2'd0;
      end
    end
  end

  assign score_add_c = (streak >= 2'd2) ? 2'd2 : 2'd1;
`else
  assign score_add_c = 2'd1;
`endif

  // Saturating score add
  assign score_sum_c  = {1'b0, bus.Score} + (SCORE_W+1)'(score_add_c);
  assign score_next_c = score_sum_c[SCORE_W] ? '1 : score_sum_c[SCORE_W-1:0];

  always_ff @(posedge Clk) begin
    if (Rst) begin
      state           <= S_IDLE;
      hold_cnt        <= '0;
      bus.TimerEnable <= 1'b0;
      bus.ChildMode   <= 1'b0;
      bus.EnableScore <= 1'b0;
      bus.NewWord     <= 1'b0;
      bus.Score       <= '0;
      bus.Round       <= '0;
      bus.Misses      <= 2'd0;
      bus.GameOver    <= 1'b0;
    end else begin
      bus.TimerEnable <= 1'b0;
      bus.NewWord     <= 1'b0;
      case (state)
        S_IDLE, S_OVER: begin
          if (bus.Start) begin
            state           <= S_LOAD;
            bus.ChildMode   <= bus.ModeSw;
            bus.Score       <= '0;
            bus.Misses      <= 2'd0;
            bus.Round       <= ROUND_W'(1);
            bus.GameOver    <= 1'b0;
            bus.TimerEnable <= 1'b1;
            bus.NewWord     <= 1'b1;
          end
        end
        S_LOAD: state <= S_ARM;
        // Timer still shows the previous Timeout for one cycle after load
        S_ARM:  state <= S_PLAY;
        S_PLAY: begin
          if (correct_c || miss_c) begin
            state           <= S_RESULT;
            hold_cnt        <= '0;
            bus.EnableScore <= 1'b1;
            if (correct_c) begin
              bus.Score <= score_next_c;
            end else begin
              bus.Misses <= bus.Misses + 2'd1;
            end
          end
        end
        S_RESULT: begin
          if (hold_cnt == HOLD_LAST) begin
            bus.EnableScore <= 1'b0;
            if (bus.Misses == MISS_LAST || bus.Round == ROUND_LAST) begin
              state        <= S_OVER;
              bus.GameOver <= 1'b1;
            end else begin
              state           <= S_LOAD;
              bus.Round       <= bus.Round + ROUND_W'(1);
              bus.TimerEnable <= 1'b1;
              bus.NewWord     <= 1'b1;
            end
          end else begin
            hold_cnt <= hold_cnt + HOLD_W'(1);
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_game_round_ctrl.sv
// Randomized bench for game_round_ctrl; reference model tracks the game as plain integers.
module tb_game_round_ctrl;

  localparam int unsigned NUM_ROUNDS  = 8;
  localparam int unsigned ROUND_W     = 4;
  localparam int unsigned SCORE_W     = 8;
  localparam int unsigned MAX_MISSES  = 3;
  localparam int unsigned HOLD_CYCLES = 4;
  localparam int          SCORE_MAX   = (1 << SCORE_W) - 1;

  logic Clk = 1'b0;
  logic Rst = 1'b1;
  always #5 Clk = ~Clk;

  game_round_if #(.SCORE_W(SCORE_W), .ROUND_W(ROUND_W)) bus ();

  game_round_ctrl #(
    .NUM_ROUNDS (NUM_ROUNDS),
    .ROUND_W    (ROUND_W),
    .SCORE_W    (SCORE_W),
    .MAX_MISSES (MAX_MISSES),
    .HOLD_CYCLES(HOLD_CYCLES)
  ) dut (
    .Clk(Clk),
    .Rst(Rst),
    .bus(bus)
  );

  int checks = 0;
  int errors = 0;

  // Reference game state
  int m_score, m_misses, m_round, m_streak;
  int m_child;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0d exp=%0d at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge Clk);
    #1;
  endtask

  task automatic clear_in();
    bus.Start       = 1'b0;
    bus.WordDone    = 1'b0;
    bus.WordCorrect = 1'b0;
    bus.Timeout     = 1'b0;
  endtask

  task automatic check_all_zero(input string tag);
    check_eq({tag, "_te"},    bus.TimerEnable, 0);
    check_eq({tag, "_child"}, bus.ChildMode,   0);
    check_eq({tag, "_es"},    bus.EnableScore, 0);
    check_eq({tag, "_nw"},    bus.NewWord,     0);
    check_eq({tag, "_score"}, bus.Score,       0);
    check_eq({tag, "_round"}, bus.Round,       0);
    check_eq({tag, "_miss"},  bus.Misses,      0);
    check_eq({tag, "_over"},  bus.GameOver,    0);
  endtask

  task automatic check_tally(input string tag);
    check_eq({tag, "_score"}, bus.Score,     m_score);
    check_eq({tag, "_miss"},  bus.Misses,    m_misses);
    check_eq({tag, "_round"}, bus.Round,     m_round);
    check_eq({tag, "_child"}, bus.ChildMode, m_child);
  endtask

  task automatic model_correct();
    int add;
    add = 1;
`ifdef STREAK_BONUS_EN
    if (m_streak >= 2) add = 2;
`endif
    m_score  = (m_score + add > SCORE_MAX) ? SCORE_MAX : m_score + add;
    m_streak = (m_streak >= 3) ? 3 : m_streak + 1;
  endtask

  task automatic model_miss();
    m_misses++;
    m_streak = 0;
  endtask

  // Pulse Start from IDLE or OVER; afterwards the bench sits in the LOAD cycle
  task automatic start_game(input int mode);
    bus.ModeSw = mode[0];
    bus.Start  = 1'b1;
    tick();
    clear_in();
    bus.ModeSw = 1'($urandom_range(0, 1));
    m_score = 0; m_misses = 0; m_round = 1; m_streak = 0; m_child = mode;
    check_eq("start_over", bus.GameOver, 0);
    check_tally("start");
  endtask

  // kind: 0 correct, 1 wrong, 2 timeout, 3 wrong+timeout, 4 correct+timeout
  task automatic play_round(input int kind, output bit over);
    check_eq("load_te", bus.TimerEnable, 1);
    check_eq("load_nw", bus.NewWord, 1);
    check_eq("load_es", bus.EnableScore, 0);
    check_tally("load");
    bus.Timeout = 1'($urandom_range(0, 1));
    tick();
    check_eq("arm_te", bus.TimerEnable, 0);
    check_eq("arm_nw", bus.NewWord, 0);
    bus.Timeout = 1'($urandom_range(0, 1));
    tick();
    bus.Timeout = 1'b0;
    repeat ($urandom_range(0, 3)) begin
      bus.Start       = 1'($urandom_range(0, 1));
      bus.WordCorrect = 1'($urandom_range(0, 1));
      tick();
      clear_in();
      check_eq("play_es", bus.EnableScore, 0);
      check_eq("play_te", bus.TimerEnable, 0);
      check_tally("play");
    end
    case (kind)
      0: begin bus.WordDone = 1'b1; bus.WordCorrect = 1'b1; end
      1: begin bus.WordDone = 1'b1; bus.WordCorrect = 1'b0; end
      2: begin bus.Timeout  = 1'b1; end
      3: begin bus.WordDone = 1'b1; bus.WordCorrect = 1'b0; bus.Timeout = 1'b1; end
      default: begin bus.WordDone = 1'b1; bus.WordCorrect = 1'b1; bus.Timeout = 1'b1; end
    endcase
    tick();
    clear_in();
    if (kind == 0 || kind == 4) model_correct();
    else model_miss();
    check_eq("result_es", bus.EnableScore, 1);
    check_tally("result");
    for (int k = 1; k <= int'(HOLD_CYCLES); k++) begin
      bus.WordDone    = 1'($urandom_range(0, 1));
      bus.WordCorrect = 1'($urandom_range(0, 1));
      bus.Timeout     = 1'($urandom_range(0, 1));
      tick();
      clear_in();
      check_eq("hold_es", bus.EnableScore, (k < int'(HOLD_CYCLES)) ? 1 : 0);
      if (k < int'(HOLD_CYCLES)) check_eq("hold_te", bus.TimerEnable, 0);
    end
    over = (m_misses == int'(MAX_MISSES)) || (m_round == int'(NUM_ROUNDS));
    check_eq("after_over", bus.GameOver, over);
    if (over) begin
      check_eq("after_te", bus.TimerEnable, 0);
      check_tally("after");
    end else begin
      m_round++;
    end
  endtask

  task automatic over_idle();
    repeat (3) begin
      bus.WordDone    = 1'($urandom_range(0, 1));
      bus.WordCorrect = 1'($urandom_range(0, 1));
      bus.Timeout     = 1'($urandom_range(0, 1));
      tick();
      clear_in();
      check_eq("over_flag", bus.GameOver, 1);
      check_eq("over_te", bus.TimerEnable, 0);
      check_eq("over_es", bus.EnableScore, 0);
      check_tally("over");
    end
  endtask

  // pattern: 0 random, 1 correct/wrong+timeout/timeouts, 2 all correct
  task automatic run_game(input int mode, input int pattern);
    bit over;
    int r;
    int kind;
    over = 1'b0;
    r = 0;
    start_game(mode);
    while (!over) begin
      case (pattern)
        1: kind = (r == 0) ? 0 : ((r == 1) ? 3 : 2);
        2: kind = 0;
        default: begin
          kind = $urandom_range(0, 7);
          if (kind > 4) kind = 0;
        end
      endcase
      play_round(kind, over);
      r++;
    end
    over_idle();
  endtask

  initial begin
    clear_in();
    bus.ModeSw = 1'b0;
    Rst = 1'b1;
    repeat (3) tick();
    Rst = 1'b0;
    check_all_zero("reset");
    repeat (6) begin
      tick();
      check_eq("idle_te", bus.TimerEnable, 0);
      check_eq("idle_round", bus.Round, 0);
    end

    // Child mode, one correct word then misses until the miss limit
    run_game(1, 1);
    check_eq("missgame_round", bus.Round, 4);

    // Restart from OVER, eight correct rounds
    run_game(0, 2);
    check_eq("fullgame_round", bus.Round, NUM_ROUNDS);
`ifdef STREAK_BONUS_EN
    check_eq("fullgame_score", bus.Score, 14);
`else
    check_eq("fullgame_score", bus.Score, 8);
`endif

    // Reset in the middle of PLAY
    start_game(1);
    tick();
    tick();
    tick();
    Rst = 1'b1;
    bus.WordDone = 1'b1;
    bus.WordCorrect = 1'b1;
    repeat (3) tick();
    Rst = 1'b0;
    clear_in();
    check_all_zero("midrst");
    tick();
    check_all_zero("midrst_next");

    for (int g = 0; g < 6; g++) begin
      run_game(int'($urandom_range(0, 1)), 0);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
